regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending-write scoreboard. Sits in the decode stage of the pipelined core. Operands are read in decode, destination registers are marked busy at issue, and the marks are cleared at writeback. Decode uses the busy flags and the `busy_cnt` summary to raise hazard stalls without a separate hazard table.

## Interface
- `XLEN`, 32, data width in bits.
- `NREG`, 32, number of architectural registers; power of two, ≥ 2.
- `AW`, `$clog2(NREG)`, register address width (derived; do not override).
- `ZERO_REG`, 1, when 1 register 0 is hardwired to zero and is never busy.
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `we` input 1: writeback enable.
- `wa` input AW: writeback address.
- `wd` input XLEN: writeback data.
- `ra1`, `ra2` input AW each: read addresses.
- `rd1`, `rd2` output XLEN each: read data (combinational).
- `busy1`, `busy2` output 1 each: source register has a pending write (combinational).
- `iss_en` input 1: an instruction issues with a destination register.
- `iss_rd` input AW: destination register of the issuing instruction.
- `flush` input 1: synchronous clear of all busy bits (pipeline flush).
- `busy_cnt` output AW+1: number of registers currently busy (registered).

## Operation
- Storage is `NREG` × `XLEN` flops; a busy vector is `NREG` bits.
- **Write:** on the rising edge with `we`=1, `regs[wa]` ← `wd`.
  - When `ZERO_REG`=1 and `wa`=0, the write is discarded.
- **Read:** `rdN` = `regs[raN]`, subject to two overrides:
  - `ZERO_REG`=1 and `raN`=0 → `rdN`=0 and `busyN`=0, always.
  - `BYPASS`=1, `we`=1, `wa`=`raN`, and the zero rule does not apply → `rdN`=`wd`.
- **Busy flags:** `busyN` = `busy[raN]`, except when bypass applies (then `busyN`=0, since the value is available now).
  - With `BYPASS`=0 there is no forwarding; `busyN` = `busy[raN]`.
- **Busy update per edge**, in priority order:
  1. `flush`=1 clears the whole vector. Issue and writeback in the same cycle are ignored for busy, but the data write still happens.
  2. `iss_en`=1 sets `busy[iss_rd]`.
  3. `we`=1 clears `busy[wa]`.
  - If `iss_en` and `we` target the same register in one cycle, set wins: the new producer is still outstanding.
  - Issue to register 0 with `ZERO_REG`=1 is ignored.
  - `iss_en` to a register that is already busy leaves it busy. The scoreboard holds one bit, not a count.
  - `we` to a register that is not busy just writes data; the busy bit stays 0.
- **busy_cnt:** registered population count of the next-state busy vector. It equals the number of ones in `busy` after the edge. Range 0..`NREG` (or `NREG`-1 when `ZERO_REG`=1), hence AW+1 bits.

## Timing
- **Reset** (`rst`=1, asynchronous, no clock required):
  - All `regs` = 0, all `busy` = 0, `busy_cnt` = 0.
  - Consequently `rd1`/`rd2` = 0 and `busy1`/`busy2` = 0 while reset is held.
- Reset asserted mid-operation aborts any write in the same cycle; state is immediately zero.
- Deassertion is sampled synchronously by downstream logic. The first write can occur on the first rising edge with `rst`=0.
- **Write latency:** 1 cycle to storage.
- **Read latency:** 0 cycles (combinational). With `BYPASS`=1 a same-cycle write is visible immediately.
- Busy set/clear takes effect on the edge. `busyN` reflects it in the following cycle.
- `busy_cnt` changes on the same edge as the busy vector.
- No handshake: every input is sampled every edge. The caller guarantees at most one write and one issue per cycle.

## Test plan
- **Reset:** fill registers 5 and 10 with 99 and 12345, assert `rst` between edges → `rd1`, `rd2`, and `busy_cnt` go to 0 without a clock edge.
- **Write/read and zero register:**
  - Write 99 to register 5 and 12345 to register 10 → `ra1`=5, `ra2`=10 read 99 and 12345.
  - Write 0xDEADBEEF to register 0 → `ra1`=0 reads 0.
  - With `ZERO_REG`=0 (second instance), `ra1`=0 reads 0xDEADBEEF.
- **Bypass:** with `we`=1, `wa`=7, `wd`=0x55 and `ra1`=7 in the same cycle → `rd1`=0x55 before the edge.
  - With `BYPASS`=0 (second instance), `rd1` shows the old value until after the edge.
- **Scoreboard set/clear:**
  - Issue to register 3 → next cycle `busy1`=1 for `ra1`=3 and `busy_cnt`=1.
  - Writeback 42 to register 3 → `busy1`=0 in the same cycle via bypass, `rd1`=42, and `busy_cnt`=0 after the edge.
- **Simultaneous issue and writeback:** same cycle `iss_en`, `iss_rd`=4 and `we`, `wa`=4 → register 4 stays busy and `busy_cnt` is unchanged. Issue to register 0 → `busy_cnt` stays 0.
- **Flush:** issue to registers 1, 2, 3 over three cycles (`busy_cnt`=3), then `flush`=1 together with `iss_en` to register 9 → after the edge `busy_cnt`=0 and `busy[9]`=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with two combinational read ports,
// same-cycle write-to-read bypass and a one-bit-per-register pending-write
// scoreboard.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   we, wa, wd            writeback: data write and busy clear
//   ra1/ra2 -> rd1/rd2    read addresses / read data (combinational)
//   busy1/busy2           source register has a pending write (combinational)
//   iss_en, iss_rd        issue: mark destination register busy
//   flush                 synchronous clear of every busy bit
//   busy_cnt              registered population count of the busy vector

// One read port: zero-register override, then bypass, then array lookup.
module regfile_sb_rdport #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [XLEN-1:0]           wd,
  input  logic [AW-1:0]             ra,
  output logic [XLEN-1:0]           rd,
  output logic                      bsy
);
  logic is_zero, is_byp;

  assign is_zero = (ZERO_REG != 0) && (ra == '0);
  // A write that reset is aborting must not be forwarded either.
  assign is_byp  = (BYPASS != 0) && we && !rst && (wa == ra);

  always_comb begin
    rd  = regs[ra];
    bsy = busy[ra];
    if (is_zero) begin
      rd  = '0;
      bsy = 1'b0;
    end else if (is_byp) begin
      rd  = wd;
      bsy = 1'b0;   // value is available this cycle
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);
  localparam int NRP = 2;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt;
  logic [AW:0]               cnt_nxt;
  logic                      wr_ok, iss_ok;

  logic [NRP-1:0][AW-1:0]    ra;
  logic [NRP-1:0][XLEN-1:0]  rd;
  logic [NRP-1:0]            bsy;

  assign wr_ok  = we     && !((ZERO_REG != 0) && (wa == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));

  // Storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs     <= '0;
    else if (wr_ok) regs[wa] <= wd;
  end

  // Scoreboard next state: flush beats everything; set is applied after
  // clear so an issue and a writeback to one register leave it busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we)     busy_nxt[wa]     = 1'b0;
      if (iss_ok) busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports
  assign ra = {ra2, ra1};

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    regfile_sb_rdport #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rp (
      .regs(regs), .busy(busy), .rst(rst),
      .we(we), .wa(wa), .wd(wd),
      .ra(ra[p]), .rd(rd[p]), .bsy(bsy[p])
    );
  end

  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign busy1 = bsy[0];
  assign busy2 = bsy[1];
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            we, iss_en, flush;
  logic [AW-1:0]   wa, ra1, ra2, iss_rd;
  logic [XLEN-1:0] wd;

  logic [XLEN-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic            b1_a, b2_a, b1_b, b2_b;
  logic [AW:0]     cnt_a, cnt_b;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  // Default instance: zero register and bypass enabled
  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) u_a (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .busy1(b1_a), .busy2(b2_a),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(cnt_a)
  );

  // Plain instance: no zero register, no bypass; same stimulus
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(b1_b), .busy2(b2_b),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(cnt_b)
  );

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra1, ra2;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic [XLEN-1:0] e_rd1, e_rd2;
    logic            e_b1, e_b2;
    logic [AW:0]     e_cnt;
  } vec_t;

  vec_t        tv[$];
  logic [AW:0] sb_q[$];

  function automatic vec_t mk(logic w, int a, logic [31:0] d, int r1, int r2,
                              logic ie, int ir, logic fl,
                              logic [31:0] x1, logic xb1, logic [31:0] x2,
                              logic xb2, int xc);
    vec_t v;
    v.we = w; v.wa = AW'(a); v.wd = d; v.ra1 = AW'(r1); v.ra2 = AW'(r2);
    v.iss_en = ie; v.iss_rd = AW'(ir); v.flush = fl;
    v.e_rd1 = x1; v.e_b1 = xb1; v.e_rd2 = x2; v.e_b2 = xb2;
    v.e_cnt = (AW+1)'(xc);
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    we = 0; wa = '0; wd = '0; iss_en = 0; iss_rd = '0; flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle(); ra1 = 5'd5; ra2 = 5'd10;
    #2;
    chk("reset_rd1", rd1_a, 0);
    chk("reset_rd2", rd2_a, 0);
    chk("reset_busy1", b1_a, 0);
    chk("reset_cnt", cnt_a, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // ---- table: pre-edge combinational outputs, busy_cnt after the edge
    //       we wa wd           ra1 ra2 is ird fl  rd1 b1 rd2 b2 cnt
    tv.push_back(mk(1,  5, 99,          5, 10, 0, 0, 0, 99,  0, 0,     0, 0));
    tv.push_back(mk(1, 10, 12345,       5, 10, 0, 0, 0, 99,  0, 12345, 0, 0));
    tv.push_back(mk(0,  0, 0,           5, 10, 0, 0, 0, 99,  0, 12345, 0, 0));
    tv.push_back(mk(1,  0, 32'hDEADBEEF,0,  5, 0, 0, 0, 0,   0, 99,    0, 0));
    tv.push_back(mk(0,  0, 0,           0,  0, 0, 0, 0, 0,   0, 0,     0, 0));
    tv.push_back(mk(1,  7, 32'h55,      7,  0, 0, 0, 0, 32'h55,0,0,    0, 0));
    tv.push_back(mk(0,  0, 0,           3,  7, 1, 3, 0, 0,   0, 32'h55,0, 1));
    tv.push_back(mk(0,  0, 0,           3,  7, 0, 0, 0, 0,   1, 32'h55,0, 1));
    tv.push_back(mk(1,  3, 42,          3,  3, 0, 0, 0, 42,  0, 42,    0, 0));
    tv.push_back(mk(0,  0, 0,           3,  3, 0, 0, 0, 42,  0, 42,    0, 0));
    tv.push_back(mk(0,  0, 0,           4,  0, 1, 4, 0, 0,   0, 0,     0, 1));
    tv.push_back(mk(1,  4, 77,          4,  0, 1, 4, 0, 77,  0, 0,     0, 1));
    tv.push_back(mk(0,  0, 0,           4,  0, 0, 0, 0, 77,  1, 0,     0, 1));
    tv.push_back(mk(1,  4, 78,          4,  0, 0, 0, 0, 78,  0, 0,     0, 0));
    tv.push_back(mk(0,  0, 0,           0,  4, 1, 0, 0, 0,   0, 78,    0, 0));
    tv.push_back(mk(0,  0, 0,           1,  2, 1, 1, 0, 0,   0, 0,     0, 1));
    tv.push_back(mk(0,  0, 0,           1,  2, 1, 2, 0, 0,   1, 0,     0, 2));
    tv.push_back(mk(0,  0, 0,           2,  3, 1, 3, 0, 0,   1, 42,    0, 3));
    tv.push_back(mk(0,  0, 0,           3,  9, 1, 9, 1, 42,  1, 0,     0, 0));
    tv.push_back(mk(0,  0, 0,           9,  1, 0, 0, 0, 0,   0, 0,     0, 0));
    tv.push_back(mk(1,  9, 5,           9,  0, 0, 0, 1, 5,   0, 0,     0, 0));
    tv.push_back(mk(0,  0, 0,           9,  6, 1, 6, 0, 5,   0, 0,     0, 1));
    tv.push_back(mk(0,  0, 0,           6,  0, 1, 6, 0, 0,   1, 0,     0, 1));
    tv.push_back(mk(1,  6, 1,           6,  0, 0, 0, 0, 1,   0, 0,     0, 0));
    tv.push_back(mk(0,  0, 0,           6,  6, 0, 0, 0, 1,   0, 1,     0, 0));

    foreach (tv[i]) begin
      @(negedge clk);
      we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd;
      ra1 = tv[i].ra1; ra2 = tv[i].ra2;
      iss_en = tv[i].iss_en; iss_rd = tv[i].iss_rd; flush = tv[i].flush;
      sb_q.push_back(tv[i].e_cnt);
      #1;
      chk($sformatf("v%0d_rd1", i),   rd1_a, tv[i].e_rd1);
      chk($sformatf("v%0d_busy1", i), b1_a,  tv[i].e_b1);
      chk($sformatf("v%0d_rd2", i),   rd2_a, tv[i].e_rd2);
      chk($sformatf("v%0d_busy2", i), b2_a,  tv[i].e_b2);
      @(posedge clk); #1;
      if (sb_q.size() == 0) chk($sformatf("v%0d_sb_empty", i), 1, 0);
      else chk($sformatf("v%0d_cnt", i), cnt_a, sb_q.pop_front());
    end

    // ---- no zero register: reg 0 keeps the 0xDEADBEEF written earlier
    @(negedge clk); idle(); ra1 = 5'd0; ra2 = 5'd9; #1;
    chk("nz_rd0", rd1_b, 32'hDEADBEEF);
    chk("nz_rd9", rd2_b, 5);
    chk("z_rd0",  rd1_a, 0);

    // ---- no bypass: old value until after the edge
    @(negedge clk); we = 1; wa = 5'd7; wd = 32'hAA; ra1 = 5'd7; #1;
    chk("byp_rd1",   rd1_a, 32'hAA);
    chk("nobyp_old", rd1_b, 32'h55);
    @(posedge clk); #1;
    chk("nobyp_new", rd1_b, 32'hAA);

    // ---- issue to register 0: ignored only when it is hardwired
    @(negedge clk); idle(); iss_en = 1; iss_rd = 5'd0; ra1 = 5'd0;
    @(posedge clk); #1;
    chk("iss0_cnt_z",  cnt_a, 0);
    chk("iss0_cnt_nz", cnt_b, 1);
    chk("iss0_busy_z",  b1_a, 0);
    chk("iss0_busy_nz", b1_b, 1);
    @(negedge clk); idle(); we = 1; wa = 5'd0; wd = 32'h0; ra1 = 5'd0; #1;
    chk("nobyp_busy_held", b1_b, 1);
    @(posedge clk); #1;
    chk("wb0_cnt_nz", cnt_b, 0);

    // ---- asynchronous reset between edges
    @(negedge clk); idle(); iss_en = 1; iss_rd = 5'd3; ra1 = 5'd5; ra2 = 5'd10;
    @(posedge clk); #1;
    chk("pre_rst_cnt", cnt_a, 1);
    @(negedge clk); idle(); #1;
    chk("pre_rst_rd1", rd1_a, 99);
    chk("pre_rst_rd2", rd2_a, 12345);
    #1 rst = 1; #1;
    chk("async_rst_rd1", rd1_a, 0);
    chk("async_rst_rd2", rd2_a, 0);
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_nz_rd0", rd1_b, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("post_rst_rd1", rd1_a, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
